// File: rtl/afifo_stream_reader.sv
// Read-side consumer for the asynchronous FIFO: drains the FIFO read port into a
// 2-entry prefetch buffer and presents the words as a bubble-free valid/ready stream.
module afifo_stream_reader #(
  parameter int Width = 8
) (
  input  logic             RDclk,
  input  logic             reset,
  input  logic             Flush,
  input  logic             FIFOempty,
  input  logic [Width-1:0] RDdata,
  output logic             RDreq,
  output logic             OUTvalid,
  input  logic             OUTready,
  output logic [Width-1:0] OUTdata,
  output logic [1:0]       Occupancy
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pend_q, pend_d;

  logic [1:0] used;
  logic       fire;
  logic       pop;
  logic       capture;

  assign used      = count_q + {1'b0, pend_q};
  assign OUTvalid  = (count_q != 2'd0) && !Flush;
  assign OUTdata   = (count_q != 2'd0) ? mem_q[head_q] : '0;
  assign pop       = OUTvalid && OUTready;
  // A pop this cycle frees a slot, so OUTready feeds RDreq combinationally.
  assign RDreq     = !reset && !Flush && !FIFOempty && ((used < 2'd2) || pop);
  assign fire      = RDreq && !FIFOempty;
  assign capture   = pend_q && !Flush;
  assign Occupancy = used;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pend_d  = pend_q;
    if (Flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = '0;
      pend_d  = 1'b0;
    end else begin
      pend_d = fire;
      if (capture) begin
        mem_d[tail_q] = RDdata;
        tail_d        = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, capture} - {1'b0, pop};
    end
  end

  always_ff @(posedge RDclk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_afifo_stream_reader.sv
// Directed bench for afifo_stream_reader: per-cycle vector table plus stream,
// empty-toggling and async-reset sequences against a behavioural FIFO.
module tb_afifo_stream_reader;

  logic       RDclk;
  logic       reset;
  logic       Flush;
  logic       FIFOempty;
  logic [7:0] RDdata;
  logic       RDreq;
  logic       OUTvalid;
  logic       OUTready;
  logic [7:0] OUTdata;
  logic [1:0] Occupancy;

  int checks;
  int failures;

  afifo_stream_reader #(.Width(8)) dut (
    .RDclk     (RDclk),
    .reset     (reset),
    .Flush     (Flush),
    .FIFOempty (FIFOempty),
    .RDdata    (RDdata),
    .RDreq     (RDreq),
    .OUTvalid  (OUTvalid),
    .OUTready  (OUTready),
    .OUTdata   (OUTdata),
    .Occupancy (Occupancy)
  );

  initial RDclk = 1'b0;
  always #5 RDclk = ~RDclk;

  typedef struct {
    logic       flush;
    logic       fe;
    logic [7:0] rd;
    logic       rdy;
    logic       e_req;
    logic       e_val;
    logic [7:0] e_data;
    logic [1:0] e_occ;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic flush, logic fe, logic [7:0] rd, logic rdy,
                              logic e_req, logic e_val, logic [7:0] e_data, logic [1:0] e_occ);
    vec_t v;
    v.flush = flush; v.fe = fe; v.rd = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_val = e_val; v.e_data = e_data; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream against a behavioural FIFO; every popped word is checked in order.
  task automatic run_stream(input int n, input bit toggle, input logic [7:0] base);
    logic [7:0] fifo [$];
    logic [7:0] exp  [$];
    bit   last_fire;
    int   pops, fires, first_pop, last_pop;
    for (int i = 0; i < n; i++) begin
      fifo.push_back(base + 8'(i));
      exp.push_back(base + 8'(i));
    end
    last_fire = 1'b0;
    pops = 0; fires = 0; first_pop = -1; last_pop = -1;
    OUTready = 1'b1;
    Flush    = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge RDclk);
      if (last_fire) RDdata = fifo.pop_front();
      FIFOempty = (fifo.size() == 0) || (toggle && cyc[0]);
      #1;
      if (FIFOempty && RDreq) chk("rdreq_while_empty", 32'(RDreq), 32'd0);
      last_fire = RDreq && !FIFOempty;
      if (last_fire) fires++;
      if (OUTvalid && OUTready) begin
        if (exp.size() == 0) chk("extra_word", 32'(OUTdata), 32'hFFFF);
        else chk("stream_order", 32'(OUTdata), 32'(exp.pop_front()));
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
      if (pops == n && Occupancy == 2'd0 && fifo.size() == 0) break;
    end
    chk("stream_pops", 32'(pops), 32'(n));
    chk("stream_fires", 32'(fires), 32'(n));
    chk("stream_drained", 32'(Occupancy), 32'd0);
    if (!toggle) begin
      chk("stream_first_latency", 32'(first_pop), 32'd2);
      chk("stream_no_gap", 32'(last_pop - first_pop), 32'(n - 1));
    end
    FIFOempty = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;

    // Row order: flush, FIFOempty, RDdata, OUTready | RDreq, OUTvalid, OUTdata, Occupancy
    vecs[0]  = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 0);
    vecs[1]  = mk(0, 0, 8'h11, 1,  1, 0, 8'h00, 1);
    vecs[2]  = mk(0, 0, 8'h22, 1,  1, 1, 8'h11, 2);
    vecs[3]  = mk(0, 1, 8'h33, 1,  0, 1, 8'h22, 2);
    vecs[4]  = mk(0, 1, 8'h33, 1,  0, 1, 8'h33, 1);
    vecs[5]  = mk(0, 1, 8'h33, 1,  0, 0, 8'h00, 0);
    // Backpressure: five words, consumer stalled then released.
    vecs[6]  = mk(0, 0, 8'h33, 0,  1, 0, 8'h00, 0);
    vecs[7]  = mk(0, 0, 8'hA1, 0,  1, 0, 8'h00, 1);
    vecs[8]  = mk(0, 0, 8'hA2, 0,  0, 1, 8'hA1, 2);
    vecs[9]  = mk(0, 0, 8'hA2, 0,  0, 1, 8'hA1, 2);
    vecs[10] = mk(0, 0, 8'hA2, 0,  0, 1, 8'hA1, 2);
    vecs[11] = mk(0, 0, 8'hA2, 1,  1, 1, 8'hA1, 2);
    vecs[12] = mk(0, 0, 8'hA3, 1,  1, 1, 8'hA2, 2);
    vecs[13] = mk(0, 0, 8'hA4, 1,  1, 1, 8'hA3, 2);
    vecs[14] = mk(0, 1, 8'hA5, 1,  0, 1, 8'hA4, 2);
    vecs[15] = mk(0, 1, 8'hA5, 1,  0, 1, 8'hA5, 1);
    vecs[16] = mk(0, 1, 8'hA5, 1,  0, 0, 8'h00, 0);
    // Flush with one word buffered and one in flight; B2 is dropped.
    vecs[17] = mk(0, 0, 8'hA5, 0,  1, 0, 8'h00, 0);
    vecs[18] = mk(0, 0, 8'hB1, 0,  1, 0, 8'h00, 1);
    vecs[19] = mk(1, 0, 8'hB2, 0,  0, 0, 8'hB1, 2);
    vecs[20] = mk(0, 0, 8'hB2, 1,  1, 0, 8'h00, 0);
    vecs[21] = mk(0, 1, 8'hB3, 1,  0, 0, 8'h00, 1);
    vecs[22] = mk(0, 1, 8'hB3, 1,  0, 1, 8'hB3, 1);
    vecs[23] = mk(0, 1, 8'hB3, 1,  0, 0, 8'h00, 0);

    reset = 1'b1; Flush = 1'b0; FIFOempty = 1'b0; RDdata = 8'h5A; OUTready = 1'b1;
    #12;
    chk("reset_rdreq", 32'(RDreq), 32'd0);
    chk("reset_valid", 32'(OUTvalid), 32'd0);
    chk("reset_data", 32'(OUTdata), 32'd0);
    chk("reset_occ", 32'(Occupancy), 32'd0);
    @(posedge RDclk);
    chk("reset_held_occ", 32'(Occupancy), 32'd0);
    @(negedge RDclk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge RDclk);
      Flush = vecs[i].flush; FIFOempty = vecs[i].fe; RDdata = vecs[i].rd; OUTready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_rdreq", i), 32'(RDreq), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d_valid", i), 32'(OUTvalid), 32'(vecs[i].e_val));
      chk($sformatf("vec%0d_data", i), 32'(OUTdata), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d_occ", i), 32'(Occupancy), 32'(vecs[i].e_occ));
    end

    run_stream(16, 1'b0, 8'h40);
    run_stream(8, 1'b1, 8'h80);

    // Async reset between edges while a burst is in progress.
    @(negedge RDclk);
    Flush = 1'b0; FIFOempty = 1'b0; RDdata = 8'hC1; OUTready = 1'b1;
    repeat (2) @(negedge RDclk);
    #1;
    chk("burst_valid_pre", 32'(OUTvalid), 32'd1);
    chk("burst_rdreq_pre", 32'(RDreq), 32'd1);
    chk("burst_occ_pre", 32'(Occupancy), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(OUTvalid), 32'd0);
    chk("async_rst_rdreq", 32'(RDreq), 32'd0);
    chk("async_rst_occ", 32'(Occupancy), 32'd0);
    chk("async_rst_data", 32'(OUTdata), 32'd0);
    @(negedge RDclk);
    reset = 1'b0;
    FIFOempty = 1'b1;
    #1;
    chk("post_rst_occ", 32'(Occupancy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
